// File: rtl/apb_arb_pkg.sv
// Shared types and the winner-selection function for the two-requester APB arbiter.
package apb_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_e;

  localparam int unsigned REQ_CPU = 0;
  localparam int unsigned REQ_AUX = 1;

  // Winner among unmasked requests; the caller only uses it when at least one is eligible.
  function automatic logic rr_pick(input logic [1:0] req, input logic [1:0] mask,
                                   input logic last_owner, input logic fixed);
    logic [1:0] w_eff;
    w_eff = req & ~mask;
    if (w_eff == 2'b11) rr_pick = fixed ? 1'(REQ_CPU) : ~last_owner;
    else                rr_pick = w_eff[0] ? 1'(REQ_CPU) : 1'(REQ_AUX);
  endfunction

endpackage

// File: rtl/apb_bus_arbiter.sv
// Shares one APB master command port between two requesters: latch, strobe, wait, respond.
module apb_bus_arbiter
  import apb_arb_pkg::*;
#(
  parameter int unsigned FIXED_PRIO = 0,
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  input  logic [1:0]           s_req,
  input  logic [1:0]           s_write,
  input  logic [1:0][AW-1:0]   s_addr,
  input  logic [1:0][DW-1:0]   s_wdata,
  output logic [1:0]           s_ready,
  output logic [DW-1:0]        s_rdata,
  output logic                 m_transfer,
  output logic                 m_write,
  output logic [AW-1:0]        m_addr,
  output logic [DW-1:0]        m_wdata,
  input  logic                 m_ready,
  input  logic [DW-1:0]        m_rdata,
  output logic                 grant_id
);

  arb_state_e        r_state,      w_state_nxt;
  logic              r_m_transfer, w_m_transfer_nxt;
  logic              r_m_write,    w_m_write_nxt;
  logic [AW-1:0]     r_m_addr,     w_m_addr_nxt;
  logic [DW-1:0]     r_m_wdata,    w_m_wdata_nxt;
  logic [1:0]        r_s_ready,    w_s_ready_nxt;
  logic [DW-1:0]     r_s_rdata,    w_s_rdata_nxt;
  logic              r_owner,      w_owner_nxt;
  logic              r_last_owner, w_last_owner_nxt;
  logic [1:0]        r_mask,       w_mask_nxt;
  logic              w_win;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state      <= IDLE;
      r_m_transfer <= 1'b0;
      r_m_write    <= 1'b0;
      r_m_addr     <= '0;
      r_m_wdata    <= '0;
      r_s_ready    <= '0;
      r_s_rdata    <= '0;
      r_owner      <= 1'b0;
      r_last_owner <= 1'b1;
      r_mask       <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_m_transfer <= w_m_transfer_nxt;
      r_m_write    <= w_m_write_nxt;
      r_m_addr     <= w_m_addr_nxt;
      r_m_wdata    <= w_m_wdata_nxt;
      r_s_ready    <= w_s_ready_nxt;
      r_s_rdata    <= w_s_rdata_nxt;
      r_owner      <= w_owner_nxt;
      r_last_owner <= w_last_owner_nxt;
      r_mask       <= w_mask_nxt;
    end
  end

  // Next-state logic; strobe and ready are computed one cycle ahead so they leave registered.
  always_comb begin
    w_state_nxt      = r_state;
    w_m_transfer_nxt = 1'b0;
    w_m_write_nxt    = r_m_write;
    w_m_addr_nxt     = r_m_addr;
    w_m_wdata_nxt    = r_m_wdata;
    w_s_ready_nxt    = '0;
    w_s_rdata_nxt    = r_s_rdata;
    w_owner_nxt      = r_owner;
    w_last_owner_nxt = r_last_owner;
    w_mask_nxt       = r_mask;
    w_win            = rr_pick(s_req, r_mask, r_last_owner, FIXED_PRIO != 0);
    case (r_state)
      IDLE: begin
        w_mask_nxt = '0;
        if ((s_req & ~r_mask) != 2'b00) begin
          w_m_write_nxt    = s_write[w_win];
          w_m_addr_nxt     = s_addr[w_win];
          w_m_wdata_nxt    = s_wdata[w_win];
          w_owner_nxt      = w_win;
          w_m_transfer_nxt = 1'b1;
          w_state_nxt      = ISSUE;
        end
      end
      ISSUE: w_state_nxt = WAIT;
      WAIT: begin
        if (m_ready) begin
          w_s_rdata_nxt          = m_rdata;
          w_s_ready_nxt[r_owner] = 1'b1;
          w_state_nxt            = RESP;
        end
      end
      RESP: begin
        w_last_owner_nxt    = r_owner;
        w_mask_nxt          = '0;
        w_mask_nxt[r_owner] = 1'b1;
        w_state_nxt         = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign s_ready    = r_s_ready;
  assign s_rdata    = r_s_rdata;
  assign m_transfer = r_m_transfer;
  assign m_write    = r_m_write;
  assign m_addr     = r_m_addr;
  assign m_wdata    = r_m_wdata;
  assign grant_id   = r_owner;

endmodule

// File: tb/tb_apb_bus_arbiter.sv
// Randomized bench for apb_bus_arbiter: one round-robin and one fixed-priority instance,
// checked against a transaction-level model of who should be granted and when.
module tb_apb_bus_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst        [2];
  logic [1:0]           s_req      [2];
  logic [1:0]           s_write    [2];
  logic [1:0][AW-1:0]   s_addr     [2];
  logic [1:0][DW-1:0]   s_wdata    [2];
  logic [1:0]           s_ready    [2];
  logic [DW-1:0]        s_rdata    [2];
  logic                 m_transfer [2];
  logic                 m_write    [2];
  logic [AW-1:0]        m_addr     [2];
  logic [DW-1:0]        m_wdata    [2];
  logic                 m_ready    [2];
  logic [DW-1:0]        m_rdata    [2];
  logic                 grant_id   [2];

  apb_bus_arbiter #(.FIXED_PRIO(0), .AW(AW), .DW(DW)) u_rr (
    .PCLK(clk), .PRESET(rst[0]), .s_req(s_req[0]), .s_write(s_write[0]), .s_addr(s_addr[0]),
    .s_wdata(s_wdata[0]), .s_ready(s_ready[0]), .s_rdata(s_rdata[0]), .m_transfer(m_transfer[0]),
    .m_write(m_write[0]), .m_addr(m_addr[0]), .m_wdata(m_wdata[0]), .m_ready(m_ready[0]),
    .m_rdata(m_rdata[0]), .grant_id(grant_id[0]));

  apb_bus_arbiter #(.FIXED_PRIO(1), .AW(AW), .DW(DW)) u_fix (
    .PCLK(clk), .PRESET(rst[1]), .s_req(s_req[1]), .s_write(s_write[1]), .s_addr(s_addr[1]),
    .s_wdata(s_wdata[1]), .s_ready(s_ready[1]), .s_rdata(s_rdata[1]), .m_transfer(m_transfer[1]),
    .m_write(m_write[1]), .m_addr(m_addr[1]), .m_wdata(m_wdata[1]), .m_ready(m_ready[1]),
    .m_rdata(m_rdata[1]), .grant_id(grant_id[1]));

  int n_chk = 0;
  int n_err = 0;
  logic [1:0] pend     [2];   // requesters with an unserved transaction
  int         last_srv [2];   // requester served most recently (1 after reset)

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s inst=%0d observed=0x%0h expected=0x%0h", tag, k, obs, exp);
    end
  endtask

  task automatic new_payload(input int k, input int r);
    s_write[k][r] = 1'($urandom_range(0, 1));
    s_addr[k][r]  = $urandom();
    s_wdata[k][r] = $urandom();
  endtask

  task automatic chk_all_zero(input string tag, input int k);
    chk({tag, "_xfer"},  k, 64'(m_transfer[k]), 64'(0));
    chk({tag, "_write"}, k, 64'(m_write[k]),    64'(0));
    chk({tag, "_addr"},  k, 64'(m_addr[k]),     64'(0));
    chk({tag, "_wdata"}, k, 64'(m_wdata[k]),    64'(0));
    chk({tag, "_ready"}, k, 64'(s_ready[k]),    64'(0));
    chk({tag, "_rdata"}, k, 64'(s_rdata[k]),    64'(0));
    chk({tag, "_gid"},   k, 64'(grant_id[k]),   64'(0));
  endtask

  // Arbitration rule: a lone request wins; ties go to requester 0 (fixed) or the non-last (RR).
  function automatic int exp_winner(input int k, input logic [1:0] elig);
    if (elig == 2'b11) return (k == 1) ? 0 : 1 - last_srv[k];
    return elig[0] ? 0 : 1;
  endfunction

  // Called in an IDLE cycle where the eligible requests are already driven; ends in the next IDLE.
  task automatic round(input int k, input logic [1:0] elig, output int w);
    logic          xw;
    logic [AW-1:0] xa;
    logic [DW-1:0] xd, rd;
    int            lat, o;
    w  = exp_winner(k, elig);
    o  = 1 - w;
    xw = s_write[k][w];
    xa = s_addr[k][w];
    xd = s_wdata[k][w];
    rd = '0;
    step();
    s_req[k] = pend[k];
    chk("xfer_strobe", k, 64'(m_transfer[k]), 64'(1));
    chk("grant_id",    k, 64'(grant_id[k]),   64'(w));
    chk("m_addr",      k, 64'(m_addr[k]),     64'(xa));
    chk("m_write",     k, 64'(m_write[k]),    64'(xw));
    chk("m_wdata",     k, 64'(m_wdata[k]),    64'(xd));
    chk("issue_no_rdy", k, 64'(s_ready[k]),   64'(0));
    m_ready[k] = 1'($urandom_range(0, 1));
    lat = int'($urandom_range(0, 3));
    for (int i = 0; i <= lat; i++) begin
      step();
      chk("wait_no_xfer",   k, 64'(m_transfer[k]), 64'(0));
      chk("wait_addr_hold", k, 64'(m_addr[k]),     64'(xa));
      chk("wait_no_ready",  k, 64'(s_ready[k]),    64'(0));
      m_ready[k] = (i == lat);
      m_rdata[k] = $urandom();
      if (i == lat) rd = m_rdata[k];
      if ($urandom_range(0, 1) != 0) s_addr[k][w] = $urandom();
      if (!pend[k][o] && $urandom_range(0, 3) == 0) begin
        new_payload(k, o);
        pend[k][o]  = 1'b1;
        s_req[k][o] = 1'b1;
      end
    end
    step();
    chk("s_ready_owner", k, 64'(s_ready[k]), 64'((w == 0) ? 2'b01 : 2'b10));
    chk("s_rdata",       k, 64'(s_rdata[k]), 64'(rd));
    chk("resp_addr",     k, 64'(m_addr[k]),  64'(xa));
    chk("resp_no_xfer",  k, 64'(m_transfer[k]), 64'(0));
    m_ready[k]  = 1'($urandom_range(0, 1));
    m_rdata[k]  = $urandom();
    pend[k][w]  = 1'b0;
    last_srv[k] = w;
    step();
    m_ready[k] = 1'b0;
  endtask

  task automatic run(input int k, input int n);
    int w, o, ch, gap;
    logic [1:0] elig, wb;
    new_payload(k, 0);
    new_payload(k, 1);
    pend[k]  = 2'b11;
    s_req[k] = 2'b11;
    round(k, 2'b11, w);
    for (int t = 0; t < n; t++) begin
      o  = 1 - w;
      wb = (w == 0) ? 2'b01 : 2'b10;
      ch = int'($urandom_range(0, 2));   // 0 drop, 1 hold one late cycle, 2 fresh request
      s_req[k][w] = (ch != 0);
      if (ch == 2) begin
        new_payload(k, w);
        pend[k][w] = 1'b1;
      end
      if (!pend[k][o] && $urandom_range(0, 1) != 0) begin
        new_payload(k, o);
        pend[k][o]  = 1'b1;
        s_req[k][o] = 1'b1;
      end
      elig = pend[k] & ~wb;
      if (elig != 2'b00) begin
        round(k, elig, w);
      end else if (pend[k] != 2'b00) begin
        step();
        s_req[k] = pend[k];
        chk("masked_no_xfer", k, 64'(m_transfer[k]), 64'(0));
        round(k, pend[k], w);
      end else begin
        gap = int'($urandom_range(1, 3));
        for (int i = 0; i < gap; i++) begin
          step();
          s_req[k] = pend[k];
          chk("idle_no_xfer",  k, 64'(m_transfer[k]), 64'(0));
          chk("idle_no_ready", k, 64'(s_ready[k]),    64'(0));
        end
        elig = 2'($urandom_range(1, 3));
        for (int r = 0; r < 2; r++) if (elig[r]) new_payload(k, r);
        pend[k]  = elig;
        s_req[k] = elig;
        round(k, elig, w);
      end
    end
    s_req[k] = pend[k];
  endtask

  task automatic reset_mid(input int k);
    int w;
    pend[k]       = 2'b00;
    s_req[k]      = 2'b01;
    s_write[k][0] = 1'b1;
    s_addr[k][0]  = 32'h1000_0004;
    s_wdata[k][0] = 32'hA5A5_5A5A;
    m_ready[k]    = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("pre_reset_addr", k, 64'(m_addr[k]), 64'(32'h1000_0004));
    #2 rst[k] = 1'b1;
    #1 chk_all_zero("async_rst", k);
    s_req[k] = 2'b00;
    step();
    rst[k]      = 1'b0;
    last_srv[k] = 1;
    step();
    chk("post_rst_no_xfer",  k, 64'(m_transfer[k]), 64'(0));
    chk("post_rst_no_ready", k, 64'(s_ready[k]),    64'(0));
    new_payload(k, 1);
    pend[k]  = 2'b10;
    s_req[k] = 2'b10;
    round(k, 2'b10, w);
    s_req[k] = 2'b00;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1;  s_req[k] = '0;  s_write[k] = '0;  s_addr[k] = '0;  s_wdata[k] = '0;
      m_ready[k] = 1'b0;  m_rdata[k] = '0;  pend[k] = '0;  last_srv[k] = 1;
    end
    step();
    chk_all_zero("reset", 0);
    chk_all_zero("reset", 1);
    step();
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    step();
    run(0, 40);
    reset_mid(0);
    run(1, 40);
    reset_mid(1);
    step();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
